des_mode_ctrl: RTL
==================

DES_MODE_CTRL -- requirements
Module: des_mode_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: input block FIFO depth; power of two, minimum 2.
REQ-002 Parameter CBC_EN, default 1: 1 = CBC supported; 0 = cfg_mode_in ignored, ECB only.
REQ-003 One clock, clk_in; reset rst_n_in is asynchronous and active-low.
REQ-004 clk_in  in  1  system clock, rising edge.
REQ-005 rst_n_in  in  1  asynchronous active-low reset.
REQ-006 cfg_load_in  in  1  one-cycle pulse; latches all cfg_* inputs.
REQ-007 cfg_mode_in  in  1  0 = ECB, 1 = CBC.
REQ-008 cfg_dir_in  in  1  0 = encrypt, 1 = decrypt.
REQ-009 cfg_key_in  in  64  DES key, parity bits included.
REQ-010 cfg_iv_in  in  64  CBC initial vector.
REQ-011 cfg_err_out  out  1  one-cycle pulse when cfg_load_in is rejected.
REQ-012 s_data_in/s_valid_in/s_last_in/s_ready_out  in/in/in/out  64/1/1/1  input block stream; s_last_in marks the final block of a message.
REQ-013 m_data_out/m_valid_out/m_last_out/m_ready_in  out/out/out/in  64/1/1/1  output block stream.
REQ-014 core_data_out/core_key_out  out  64/64  operands driven to the DES core.
REQ-015 core_mode_out/core_verify_out/core_start_out  out  1/1/1  DES core direction, parity-verify enable (tied 1), start pulse.
REQ-016 core_ready_in/core_done_in/core_result_in  in  1/1/64  DES core idle flag, one-cycle done pulse, result.
REQ-017 busy_out  out  1  high while FIFO non-empty or FSM not IDLE.

Function
REQ-018 Input transfer occurs on s_valid_in && s_ready_out; s_ready_out = FIFO not full; FIFO stores {last, data}.
REQ-019 Simultaneous FIFO push and pop when full are not allowed (ready is low); push and pop in the same cycle with the FIFO non-full are both honoured.
REQ-020 FSM states: IDLE -> WAIT_RDY (FIFO non-empty) -> START (core_ready_in=1) -> WAIT_DONE (core_done_in=1) -> OUTPUT -> IDLE (m_valid_out && m_ready_in).
REQ-021 In START, core_start_out is high for exactly one cycle, with core_data_out/core_key_out/core_mode_out stable from START until core_done_in.
REQ-022 The FIFO pops at the START cycle; the popped block is held in a block register.
REQ-023 ECB: core_data_out = block; m_data_out = core_result_in captured at done.
REQ-024 CBC encrypt: core_data_out = block XOR chain; m_data_out = result; chain <= result.
REQ-025 CBC decrypt: core_data_out = block; m_data_out = result XOR chain; chain <= block (ciphertext).
REQ-026 After an output with m_last_out=1 is accepted, chain <= latched IV.
REQ-027 m_valid_out holds with stable data/last until m_ready_in; no new core start until then.
REQ-028 cfg_load_in is accepted only when busy_out=0; the chain register is then loaded with cfg_iv_in.
REQ-029 cfg_load_in while busy_out=1: configuration unchanged, cfg_err_out pulses for one cycle.
REQ-030 Throughput is one block per core operation plus 3 control cycles; there is no block overlap.

Reset
REQ-031 On reset: FIFO empty, FSM IDLE, s_ready_out=1, m_valid_out=0, m_last_out=0, m_data_out=0, core_start_out=0, cfg_err_out=0, busy_out=0.
REQ-032 On reset: key, IV, chain, mode and dir registers = 0; core_verify_out = 1.
REQ-033 Reset asserted mid-operation aborts immediately; a pending core_done_in after release is ignored (FSM in IDLE).

Structure
REQ-034 Package des_pkg holds the state enum (IDLE, WAIT_RDY, START, WAIT_DONE, OUTPUT), the mode and dir encodings, and the 64-bit block typedef.
REQ-035 Sub-module des_fifo (parametrised width and depth, synchronous FIFO) implements the input buffer.
REQ-036 The DES core is instantiated outside this block and connected through the core_* ports.

Verification
REQ-037 ECB encrypt: key 133457799BBCDFF1, data 0123456789ABCDEF -> m_data_out 85E813540F0AB405, m_last_out as sent.
REQ-038 CBC encrypt then decrypt of 4 blocks (IV 0000000000000000, last on block 4) -> decrypt output equals the original plaintext; chain is restored to the IV after the last block.
REQ-039 Backpressure: m_ready_in held low 20 cycles with 4 blocks queued -> FIFO fills, s_ready_out=0, no data loss or reorder.
REQ-040 cfg_load_in with busy_out=1 -> cfg_err_out pulses once; the next message still uses the old key.
REQ-041 Reset asserted during WAIT_DONE -> all outputs take their reset values; the next message is correct from IV.
REQ-042 Random 200 blocks against a reference model, all four mode/dir combinations -> zero mismatches.

Source files
------------

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared types and encodings for the DES mode controller
package des_pkg;

    typedef logic [63:0] block_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        START,
        WAIT_DONE,
        OUTPUT
    } state_t;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;
    localparam logic DIR_ENC  = 1'b0;
    localparam logic DIR_DEC  = 1'b1;

endpackage

// File: rtl/des_fifo.sv
// rtl/des_fifo.sv - synchronous FIFO with first-word-fall-through read port
module des_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/des_mode_ctrl.sv
// rtl/des_mode_ctrl.sv - ECB/CBC block chaining controller in front of an external DES core
module des_mode_ctrl
    import des_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CBC_EN     = 1
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         cfg_load_in,
    input  logic         cfg_mode_in,
    input  logic         cfg_dir_in,
    input  logic [63:0]  cfg_key_in,
    input  logic [63:0]  cfg_iv_in,
    output logic         cfg_err_out,
    input  logic [63:0]  s_data_in,
    input  logic         s_valid_in,
    input  logic         s_last_in,
    output logic         s_ready_out,
    output logic [63:0]  m_data_out,
    output logic         m_valid_out,
    output logic         m_last_out,
    input  logic         m_ready_in,
    output logic [63:0]  core_data_out,
    output logic [63:0]  core_key_out,
    output logic         core_mode_out,
    output logic         core_verify_out,
    output logic         core_start_out,
    input  logic         core_ready_in,
    input  logic         core_done_in,
    input  logic [63:0]  core_result_in,
    output logic         busy_out
);

    state_t      state;
    state_t      state_nxt;
    logic [64:0] head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        cfg_accept;
    logic        cbc;

    block_t      key_q;
    block_t      iv_q;
    block_t      chain_q;
    block_t      block_q;
    block_t      operand_q;
    block_t      result_q;
    logic        mode_q;
    logic        dir_q;
    logic        last_q;
    logic        cfg_err_q;

    des_fifo #(
        .WIDTH (65),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .wr_data ({s_last_in, s_data_in}),
        .wr_en   (s_valid_in),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!fifo_empty)   state_nxt = WAIT_RDY;
            WAIT_RDY:  if (core_ready_in) state_nxt = START;
            START:                        state_nxt = WAIT_DONE;
            WAIT_DONE: if (core_done_in)  state_nxt = OUTPUT;
            OUTPUT:    if (m_ready_in)    state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_start_out = 1'b0;
        m_valid_out    = 1'b0;
        pop            = 1'b0;
        case (state)
            START:   begin core_start_out = 1'b1; pop = 1'b1; end
            OUTPUT:  m_valid_out = 1'b1;
            default: ;
        endcase
    end

    assign busy_out        = !fifo_empty || (state != IDLE);
    assign s_ready_out     = !fifo_full;
    assign cfg_accept      = cfg_load_in && !busy_out;
    assign cbc             = (mode_q == MODE_CBC);
    assign cfg_err_out     = cfg_err_q;
    assign m_data_out      = result_q;
    assign m_last_out      = m_valid_out && last_q;
    assign core_data_out   = operand_q;
    assign core_key_out    = key_q;
    assign core_mode_out   = dir_q;
    assign core_verify_out = 1'b1;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            key_q     <= '0;
            iv_q      <= '0;
            mode_q    <= MODE_ECB;
            dir_q     <= DIR_ENC;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_load_in && busy_out;
            if (cfg_accept) begin
                key_q  <= cfg_key_in;
                iv_q   <= cfg_iv_in;
                mode_q <= (CBC_EN != 0) ? cfg_mode_in : MODE_ECB;
                dir_q  <= cfg_dir_in;
            end
        end
    end

    // Operand is registered on entry to START so it is stable for the whole core operation.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            block_q   <= '0;
            operand_q <= '0;
            last_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            if (state == WAIT_RDY && core_ready_in) begin
                block_q   <= head[63:0];
                last_q    <= head[64];
                operand_q <= (cbc && dir_q == DIR_ENC) ? (head[63:0] ^ chain_q) : head[63:0];
            end
            if (state == WAIT_DONE && core_done_in)
                result_q <= (cbc && dir_q == DIR_DEC) ? (core_result_in ^ chain_q) : core_result_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            chain_q <= '0;
        else if (cfg_accept)
            chain_q <= cfg_iv_in;
        else if (state == WAIT_DONE && core_done_in && cbc)
            chain_q <= (dir_q == DIR_ENC) ? core_result_in : block_q;
        else if (state == OUTPUT && m_ready_in && last_q)
            chain_q <= iv_q;
    end

endmodule
